temp_ctrl_sequencer: RTL and testbench

Multi-cycle controller that time-shares the team's 32-bit 8-opcode ALU to run one heater/cooler hysteresis decision per accepted temperature sample.
- Per sample, it drives ALU opcode/operands in four consecutive cycles, latches each result, then updates the heater/cooler outputs and a sample counter.
- Sits between the I2C sensor readout (sample producer) and the actuator drivers; the ALU is instantiated beside it at the same top level.

---
 rtl/temp_ctrl_sequencer_pkg.sv | 31 +++
 rtl/temp_ctrl_sequencer.sv | 164 ++++++++++++++++
 tb/tb_temp_ctrl_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/temp_ctrl_sequencer_pkg.sv
// Shared definitions for the temperature controller sequencer and its external ALU.
package temp_ctrl_sequencer_pkg;

    localparam int unsigned ALU_DATA_W = 32;

    typedef enum logic [2:0] {
        OP_PASS_A = 3'b000,
        OP_ADD    = 3'b001,
        OP_SUB    = 3'b010,
        OP_AND    = 3'b011,
        OP_OR     = 3'b100,
        OP_INC    = 3'b101,
        OP_DEC    = 3'b110,
        OP_PASS_B = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_CNT  = 3'd4,
        ST_UPD  = 3'd5
    } state_e;

    typedef struct packed {
        logic heater;
        logic cooler;
    } act_t;

endpackage

// File: rtl/temp_ctrl_sequencer.sv
// Hysteresis heater/cooler controller; time-shares an external ALU over four
// cycles per sample (err, err-hyst, err+hyst, count+1) and applies the decision in UPD.
module temp_ctrl_sequencer
    import temp_ctrl_sequencer_pkg::*;
#(
    parameter int unsigned DATA_W         = ALU_DATA_W,
    parameter bit          OFF_ON_DISABLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] setpoint,
    input  logic [DATA_W-1:0] hyst,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_y,
    output logic              heater_on,
    output logic              cooler_on,
    output logic [DATA_W-1:0] temp_err,
    output logic [DATA_W-1:0] sample_count,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic [DATA_W-1:0] setpoint_q, setpoint_d;
    logic [DATA_W-1:0] hyst_q, hyst_d;
    logic [DATA_W-1:0] err_q, err_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [DATA_W-1:0] cnt_next_q, cnt_next_d;
    logic [DATA_W-1:0] temp_err_q, temp_err_d;
    logic [DATA_W-1:0] count_q, count_d;
    act_t              act_q, act_d;
    alu_op_e           alu_op;

    // hi = err - hyst, lo = err + hyst; outside the band drive, at/through the
    // setpoint release, inside the band hold the previous actuator state.
    function automatic act_t decide(input logic [DATA_W-1:0] err,
                                    input logic [DATA_W-1:0] hi,
                                    input logic [DATA_W-1:0] lo,
                                    input act_t              cur);
        act_t r;
        r = cur;
        if (!hi[DATA_W-1] && (hi != '0))
            r.cooler = 1'b1;
        else if (err[DATA_W-1] || (err == '0))
            r.cooler = 1'b0;
        if (lo[DATA_W-1])
            r.heater = 1'b1;
        else if (!err[DATA_W-1])
            r.heater = 1'b0;
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        sample_d   = sample_q;
        setpoint_d = setpoint_q;
        hyst_d     = hyst_q;
        err_d      = err_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        cnt_next_d = cnt_next_q;
        temp_err_d = temp_err_q;
        count_d    = count_q;
        act_d      = act_q;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = OP_PASS_A;

        unique case (state_q)
            ST_IDLE: begin
                if (!enable && OFF_ON_DISABLE)
                    act_d = '0;
                if (sample_valid && enable) begin
                    sample_d   = sample;
                    setpoint_d = setpoint;
                    hyst_d     = hyst[DATA_W-1] ? '0 : hyst;
                    state_d    = ST_ERR;
                end
            end
            ST_ERR: begin
                alu_op  = OP_SUB;
                alu_a   = sample_q;
                alu_b   = setpoint_q;
                err_d   = alu_y;
                state_d = ST_HI;
            end
            ST_HI: begin
                alu_op  = OP_SUB;
                alu_a   = err_q;
                alu_b   = hyst_q;
                hi_d    = alu_y;
                state_d = ST_LO;
            end
            ST_LO: begin
                alu_op  = OP_ADD;
                alu_a   = err_q;
                alu_b   = hyst_q;
                lo_d    = alu_y;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                alu_op     = OP_INC;
                alu_a      = count_q;
                cnt_next_d = alu_y;
                state_d    = ST_UPD;
            end
            ST_UPD: begin
                temp_err_d = err_q;
                count_d    = cnt_next_q;
                act_d      = decide(err_q, hi_q, lo_q, act_q);
                if (!enable && OFF_ON_DISABLE)
                    act_d = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sample_q   <= '0;
            setpoint_q <= '0;
            hyst_q     <= '0;
            err_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            cnt_next_q <= '0;
            temp_err_q <= '0;
            count_q    <= '0;
            act_q      <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            setpoint_q <= setpoint_d;
            hyst_q     <= hyst_d;
            err_q      <= err_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            cnt_next_q <= cnt_next_d;
            temp_err_q <= temp_err_d;
            count_q    <= count_d;
            act_q      <= act_d;
        end
    end

    assign sample_ready = (state_q == ST_IDLE) && enable;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_UPD);
    assign alu_opcode   = alu_op;
    assign heater_on    = act_q.heater;
    assign cooler_on    = act_q.cooler;
    assign temp_err     = temp_err_q;
    assign sample_count = count_q;

endmodule

// File: tb/tb_temp_ctrl_sequencer.sv
// Directed bench for temp_ctrl_sequencer with a behavioural model of the shared ALU.
module tb_temp_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        sample_valid;
    logic        sample_ready;
    logic [31:0] sample, setpoint, hyst;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_opcode;
    logic        heater_on, cooler_on;
    logic [31:0] temp_err, sample_count;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    temp_ctrl_sequencer #(
        .DATA_W        (32),
        .OFF_ON_DISABLE(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .sample      (sample),
        .setpoint    (setpoint),
        .hyst        (hyst),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_y       (alu_y),
        .heater_on   (heater_on),
        .cooler_on   (cooler_on),
        .temp_err    (temp_err),
        .sample_count(sample_count),
        .busy        (busy),
        .done        (done)
    );

    always_comb begin
        case (alu_opcode)
            3'b000:  alu_y = alu_a;
            3'b001:  alu_y = alu_a + alu_b;
            3'b010:  alu_y = alu_a - alu_b;
            3'b011:  alu_y = alu_a & alu_b;
            3'b100:  alu_y = alu_a | alu_b;
            3'b101:  alu_y = alu_a + 32'd1;
            3'b110:  alu_y = alu_a - 32'd1;
            default: alu_y = alu_b;
        endcase
    end

    typedef struct {
        logic [31:0] s;
        logic [31:0] sp;
        logic [31:0] h;
        logic        eh;
        logic        ec;
        logic [31:0] eerr;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one sample into the transfer edge; returns #1 after that edge (ERR cycle).
    task automatic start(input logic [31:0] s, input logic [31:0] sp, input logic [31:0] h,
                         input string tag);
        @(negedge clk);
        sample       = s;
        setpoint     = sp;
        hyst         = h;
        sample_valid = 1'b1;
        chk({tag, " ready"}, 32'(sample_ready), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Steps cycles until done is seen (bounded), recording opcodes in cycles 1..4.
    task automatic wait_done(input int lat0, output int lat, output logic [11:0] ops);
        lat = lat0;
        ops = '0;
        while (!done && lat < 20) begin
            if (lat >= 1 && lat <= 4)
                ops[11 - 3*(lat-1) -: 3] = alu_opcode;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run(input vec_t v, input bit junk, input string tag);
        int          lat;
        logic [11:0] ops;
        start(v.s, v.sp, v.h, tag);
        if (junk)
            sample = 32'd100;
        else
            sample_valid = 1'b0;
        wait_done(1, lat, ops);
        sample_valid = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'd5);
        chk({tag, " opseq"}, 32'(ops), 32'(12'b010_010_001_101));
        @(posedge clk);
        #1;
        chk({tag, " done_pulse"}, 32'({done, busy}), 32'd0);
        chk({tag, " heater"}, 32'(heater_on), 32'(v.eh));
        chk({tag, " cooler"}, 32'(cooler_on), 32'(v.ec));
        chk({tag, " temp_err"}, temp_err, v.eerr);
        chk({tag, " count"}, sample_count, v.ecnt);
        chk({tag, " mutex"}, 32'(heater_on & cooler_on), 32'd0);
    endtask

    initial begin
        int          lat;
        int          seen_done;
        logic [11:0] ops;
        vec_t        w;

        vecs[0] = '{32'd265, 32'd250, 32'd10, 1'b0, 1'b1, 32'd15, 32'd1};
        vecs[1] = '{32'd255, 32'd250, 32'd10, 1'b0, 1'b1, 32'd5, 32'd2};
        vecs[2] = '{32'd250, 32'd250, 32'd10, 1'b0, 1'b0, 32'd0, 32'd3};
        vecs[3] = '{32'd235, 32'd250, 32'd10, 1'b1, 1'b0, 32'hFFFF_FFF1, 32'd4};
        vecs[4] = '{32'd245, 32'd250, 32'd10, 1'b1, 1'b0, 32'hFFFF_FFFB, 32'd5};
        vecs[5] = '{32'd251, 32'd250, 32'd10, 1'b0, 1'b0, 32'd1, 32'd6};
        vecs[6] = '{32'd251, 32'd250, 32'hFFFF_FFF6, 1'b0, 1'b1, 32'd1, 32'd7};
        vecs[7] = '{32'hFFFF_FF9C, 32'hFFFF_FFB0, 32'd5, 1'b1, 1'b0, 32'hFFFF_FFEC, 32'd8};

        rst          = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sample       = '0;
        setpoint     = '0;
        hyst         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst heater", 32'(heater_on), 32'd0);
        chk("rst cooler", 32'(cooler_on), 32'd0);
        chk("rst count", sample_count, 32'd0);
        chk("rst temp_err", temp_err, 32'd0);
        chk("rst busy_done", 32'({busy, done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("idle ready", 32'(sample_ready), 32'd1);
        chk("idle opcode", 32'(alu_opcode), 32'd0);
        chk("idle alu_a", alu_a, 32'd0);

        for (int i = 0; i < 8; i++)
            run(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Enable low in IDLE: ready drops at once, heater clears on the next edge.
        @(negedge clk);
        enable = 1'b0;
        #1;
        chk("dis_idle ready", 32'(sample_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("dis_idle heater", 32'(heater_on), 32'd0);
        @(negedge clk);
        enable = 1'b1;

        // Counter wrap through the ALU increment.
        @(negedge clk);
        force dut.count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.count_q;
        w = '{32'd250, 32'd250, 32'd10, 1'b0, 1'b0, 32'd0, 32'd0};
        run(w, 1'b0, "wrap");

        // sample_valid held high through the busy period must not recapture.
        w = '{32'd265, 32'd250, 32'd10, 1'b0, 1'b1, 32'd15, 32'd1};
        run(w, 1'b1, "busy_valid");

        // Enable dropped in the LO cycle with the cooler on.
        start(32'd265, 32'd250, 32'd10, "dis_mid");
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        wait_done(3, lat, ops);
        chk("dis_mid latency", 32'(lat), 32'd5);
        @(posedge clk);
        #1;
        chk("dis_mid cooler", 32'(cooler_on), 32'd0);
        chk("dis_mid heater", 32'(heater_on), 32'd0);
        chk("dis_mid count", sample_count, 32'd2);
        chk("dis_mid temp_err", temp_err, 32'd15);
        @(negedge clk);
        enable = 1'b1;

        // Reset in the HI cycle aborts the sequence without a done pulse.
        w = '{32'd265, 32'd250, 32'd10, 1'b0, 1'b1, 32'd15, 32'd3};
        run(w, 1'b0, "pre_rst");
        start(32'd265, 32'd250, 32'd10, "rst_mid");
        sample_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 0)
                rst = 1'b0;
            if (done)
                seen_done++;
        end
        chk("rst_mid no_done", 32'(seen_done), 32'd0);
        chk("rst_mid cooler", 32'(cooler_on), 32'd0);
        chk("rst_mid count", sample_count, 32'd0);
        chk("rst_mid temp_err", temp_err, 32'd0);
        chk("rst_mid busy", 32'(busy), 32'd0);
        chk("rst_mid opcode", 32'(alu_opcode), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
